// File: rtl/branch_ctrl_if.sv
// Request, comparator-control and result signals between EX and the shared branch comparator.
// The slave view belongs to branch_ctrl; the master view belongs to whoever drives the requests.
interface branch_ctrl_if #(
    parameter int XLEN = 32
);
    logic            i_br_valid;
    logic            o_br_ready;
    logic [2:0]      i_br_funct3;
    logic [XLEN-1:0] i_br_pc;
    logic [XLEN-1:0] i_br_imm;
    logic            i_slt_valid;
    logic            o_slt_ready;
    logic            i_slt_unsigned;
    logic            i_slt_use_imm;
    logic            o_cmp_src_sel;
    logic            o_cmp_br_un;
    logic            o_cmp_slti_sel;
    logic            i_cmp_less;
    logic            i_cmp_equal;
    logic            o_redirect_valid;
    logic [XLEN-1:0] o_redirect_pc;
    logic            o_misalign;
    logic            o_flush;
    logic            o_br_resolved;
    logic            o_br_taken;
    logic            o_illegal;
    logic            o_slt_done;
    logic            o_slt_result;

    modport slave (
        input  i_br_valid, i_br_funct3, i_br_pc, i_br_imm,
        input  i_slt_valid, i_slt_unsigned, i_slt_use_imm,
        input  i_cmp_less, i_cmp_equal,
        output o_br_ready, o_slt_ready,
        output o_cmp_src_sel, o_cmp_br_un, o_cmp_slti_sel,
        output o_redirect_valid, o_redirect_pc, o_misalign, o_flush,
        output o_br_resolved, o_br_taken, o_illegal,
        output o_slt_done, o_slt_result
    );

    modport master (
        output i_br_valid, i_br_funct3, i_br_pc, i_br_imm,
        output i_slt_valid, i_slt_unsigned, i_slt_use_imm,
        output i_cmp_less, i_cmp_equal,
        input  o_br_ready, o_slt_ready,
        input  o_cmp_src_sel, o_cmp_br_un, o_cmp_slti_sel,
        input  o_redirect_valid, o_redirect_pc, o_misalign, o_flush,
        input  o_br_resolved, o_br_taken, o_illegal,
        input  o_slt_done, o_slt_result
    );
endinterface

// File: rtl/branch_ctrl.sv
// Arbitrates the shared comparator between branches and SLT ops, resolves branches,
// and issues the PC redirect plus the IF/ID flush window.
//
//   state    | meaning
//   IDLE     | accepting requests, branch has priority over SLT
//   REDIRECT | taken branch: redirect pulse, flush high
//   FLUSH    | flush held while the down-counter runs to 0
module branch_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    branch_ctrl_if.slave  bus
);
    localparam int CW   = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int LOAD = (FLUSH_CYCLES >= 2) ? FLUSH_CYCLES - 2 : 0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            misalign_q, misalign_d;
    logic            br_resolved_q, br_resolved_d;
    logic            br_taken_q, br_taken_d;
    logic            illegal_q, illegal_d;
    logic            slt_done_q, slt_done_d;
    logic            slt_result_q, slt_result_d;

    logic            idle;
    logic            br_grant;
    logic            slt_grant;
    logic            cond_true;
    logic            take;
    logic [XLEN-1:0] target;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        redirect_pc_d    = redirect_pc_q;
        slt_result_d     = slt_result_q;
        cond_true        = 1'b0;

        idle      = (state_q == IDLE);
        br_grant  = idle & bus.i_br_valid;
        slt_grant = idle & bus.i_slt_valid & ~bus.i_br_valid;
        target    = bus.i_br_pc + bus.i_br_imm;

        unique case (bus.i_br_funct3)
            3'b000:         cond_true = bus.i_cmp_equal;
            3'b001:         cond_true = ~bus.i_cmp_equal;
            3'b100, 3'b110: cond_true = bus.i_cmp_less;
            3'b101, 3'b111: cond_true = ~bus.i_cmp_less;
            default:        cond_true = 1'b0;
        endcase
        take = br_grant & cond_true;

        redirect_valid_d = take;
        misalign_d       = take & (target[1:0] != 2'b00);
        br_resolved_d    = br_grant;
        br_taken_d       = take;
        illegal_d        = br_grant & (bus.i_br_funct3[2:1] == 2'b01);
        slt_done_d       = slt_grant;
        if (take) begin
            redirect_pc_d = target;
        end
        if (slt_grant) begin
            slt_result_d = bus.i_cmp_less;
        end

        unique case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = REDIRECT;
                end
            end
            REDIRECT: begin
                if (FLUSH_CYCLES == 1) begin
                    state_d = IDLE;
                end else begin
                    state_d = FLUSH;
                    cnt_d   = CW'(LOAD);
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            misalign_q       <= 1'b0;
            br_resolved_q    <= 1'b0;
            br_taken_q       <= 1'b0;
            illegal_q        <= 1'b0;
            slt_done_q       <= 1'b0;
            slt_result_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            misalign_q       <= misalign_d;
            br_resolved_q    <= br_resolved_d;
            br_taken_q       <= br_taken_d;
            illegal_q        <= illegal_d;
            slt_done_q       <= slt_done_d;
            slt_result_q     <= slt_result_d;
        end
    end

    // Comparator controls follow the grant in the same cycle.
    assign bus.o_br_ready       = idle;
    assign bus.o_slt_ready      = idle & ~bus.i_br_valid;
    assign bus.o_cmp_src_sel    = slt_grant;
    assign bus.o_cmp_br_un      = (br_grant & bus.i_br_funct3[1]) | (slt_grant & bus.i_slt_unsigned);
    assign bus.o_cmp_slti_sel   = slt_grant & bus.i_slt_use_imm;
    assign bus.o_flush          = ~idle;
    assign bus.o_redirect_valid = redirect_valid_q;
    assign bus.o_redirect_pc    = redirect_pc_q;
    assign bus.o_misalign       = misalign_q;
    assign bus.o_br_resolved    = br_resolved_q;
    assign bus.o_br_taken       = br_taken_q;
    assign bus.o_illegal        = illegal_q;
    assign bus.o_slt_done       = slt_done_q;
    assign bus.o_slt_result     = slt_result_q;
endmodule
